// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and constants for the stack sequencer
package stack_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_PULL_INC = 3'd2,
        ST_PULL_RD  = 3'd3,
        ST_PULL_CAP = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Default high address byte of every stack access
    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    // Select byte k of a 24-bit word
    function automatic logic [7:0] sel_byte(input logic [23:0] d, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - multi-byte push/pull sequencer driving an external stack pointer
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_pull, req_count      direction (1 = pull) and byte count 0..3
//   push_data                bytes to push, byte count-1 written first
//   pull_data                pulled bytes, first pulled byte in [7:0]
//   done                     one-cycle completion pulse
//   txs_valid, txs_data      direct S load, honoured only in IDLE without a request
//   sp_q                     current S from the stack-pointer register
//   sp_in, sp_inc, sp_dec, sp_load  stack-pointer register data and controls
//   mem_addr, mem_we, mem_re, mem_wdata, mem_rdata  byte bus, read data one cycle after mem_re
module stack_seq
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_pull,
    input  logic [1:0]  req_count,
    input  logic [23:0] push_data,
    output logic [23:0] pull_data,
    output logic        done,
    input  logic        txs_valid,
    input  logic [7:0]  txs_data,
    input  logic [7:0]  sp_q,
    output logic [7:0]  sp_in,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic        sp_load,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_count;
    logic [1:0]  r_idx;
    logic [23:0] r_push_data;
    logic [23:0] r_pull_data;
    logic        w_accept;
    logic        w_capture;
    logic [1:0]  w_cap_idx;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    // Read data returns one cycle after PULL_RD; r_idx has already advanced past that byte.
    assign w_capture = ((r_state == ST_PULL_INC) && (r_idx != 2'd0)) || (r_state == ST_PULL_CAP);
    assign w_cap_idx = r_idx - 2'd1;

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        done      = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        sp_load   = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'h00;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_count == 2'd0)
                        w_next = ST_DONE;
                    else if (req_pull)
                        w_next = ST_PULL_INC;
                    else
                        w_next = ST_PUSH;
                end else if (txs_valid && rst_n) begin
                    // Gated by rst_n so no load strobe leaks out while reset is held
                    sp_load = 1'b1;
                end
            end
            ST_PUSH: begin
                mem_we    = 1'b1;
                sp_dec    = 1'b1;
                mem_wdata = sel_byte(r_push_data, r_idx);
                if (r_idx == 2'd0)
                    w_next = ST_DONE;
            end
            ST_PULL_INC: begin
                sp_inc = 1'b1;
                w_next = ST_PULL_RD;
            end
            ST_PULL_RD: begin
                mem_re = 1'b1;
                w_next = (r_idx == r_count - 2'd1) ? ST_PULL_CAP : ST_PULL_INC;
            end
            ST_PULL_CAP: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        sp_in    = sp_load ? txs_data : sp_q;
        mem_addr = (mem_we || mem_re) ? {STACK_PAGE, sp_q} : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= 2'd0;
            r_idx       <= 2'd0;
            r_push_data <= 24'h000000;
            r_pull_data <= 24'h000000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_count     <= req_count;
                r_push_data <= push_data;
                // Push walks bytes downward, pull walks upward from 0
                r_idx       <= req_pull ? 2'd0 : (req_count - 2'd1);
                if (req_pull)
                    r_pull_data <= 24'h000000;
            end else begin
                if (r_state == ST_PUSH)
                    r_idx <= r_idx - 2'd1;
                if (r_state == ST_PULL_RD)
                    r_idx <= r_idx + 2'd1;
                if (w_capture)
                    r_pull_data[{w_cap_idx, 3'b000} +: 8] <= mem_rdata;
            end
        end
    end

    assign pull_data = r_pull_data;

endmodule
